// File: rtl/sr_ff_monitor.sv
// sr_ff_monitor: watches an SR flip-flop through its set/reset commands and its
// q/qbar outputs, and flags value and complement mismatches.
//
// A command sampled at one edge sets the expected value that is checked against
// q at the next edge. Error status is sticky and keeps the first cause. Event
// counters saturate. With HALT_ON_ERR set, the first mismatch freezes checking
// until clr_err_i or reset.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       synchronous active-low reset
//   en_i         monitor enable; low suspends checking and forces UNK
//   s_i, r_i     set/reset commands driven to the observed flip-flop
//   q_i, qbar_i  observed flip-flop outputs
//   clr_err_i    single-cycle pulse clearing err/err_code/err_cnt (and HALT)
//   err_o        sticky error flag
//   err_code_o   first cause: 01 value, 10 complement, 11 both
//   err_cnt_o    mismatch cycles, saturating
//   set_cnt_o    count of s/r = 10 commands, saturating
//   clr_cnt_o    count of s/r = 01 commands, saturating
//   inv_cnt_o    count of s/r = 11 commands, saturating
//   mstate_o     FSM state: 00 UNK, 01 TRACK, 10 HALT
module sr_ff_monitor #(
  parameter int unsigned CNT_W       = 8,
  parameter bit          HALT_ON_ERR = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             s_i,
  input  logic             r_i,
  input  logic             q_i,
  input  logic             qbar_i,
  input  logic             clr_err_i,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] set_cnt_o,
  output logic [CNT_W-1:0] clr_cnt_o,
  output logic [CNT_W-1:0] inv_cnt_o,
  output logic [1:0]       mstate_o
);

  localparam logic [1:0] StUnk   = 2'b00;
  localparam logic [1:0] StTrack = 2'b01;
  localparam logic [1:0] StHalt  = 2'b10;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             exp_q, exp_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;

  logic check_active;
  logic val_mm;
  logic cmp_mm;
  logic any_mm;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  // Checks use the state and expected value left by the previous edge, so a
  // command is judged against q one edge after it was sampled.
  assign check_active = en_i && (state_q != StHalt);
  assign val_mm       = check_active && (state_q == StTrack) && (q_i != exp_q);
  assign cmp_mm       = check_active && (qbar_i == q_i);
  assign any_mm       = val_mm || cmp_mm;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_cnt_d  = err_cnt_q;
    set_cnt_d  = set_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    inv_cnt_d  = inv_cnt_q;

    // Clear first so a mismatch in the same cycle overrides it.
    if (clr_err_i) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
      err_cnt_d  = '0;
    end

    if (any_mm) begin
      err_d = 1'b1;
      // Keep the first cause unless this cycle also cleared the old one.
      if (!err_q || clr_err_i) begin
        err_code_d = {cmp_mm, val_mm};
      end
      err_cnt_d = clr_err_i ? CntOne : sat_inc(err_cnt_q);
    end

    if (!en_i) begin
      state_d = StUnk;
    end else if (state_q == StHalt) begin
      if (clr_err_i) begin
        state_d = StUnk;
      end
    end else if (any_mm && HALT_ON_ERR) begin
      // The command of the halting edge is discarded.
      state_d = StHalt;
    end else begin
      case ({s_i, r_i})
        2'b10: begin
          exp_d     = 1'b1;
          state_d   = StTrack;
          set_cnt_d = sat_inc(set_cnt_q);
        end
        2'b01: begin
          exp_d     = 1'b0;
          state_d   = StTrack;
          clr_cnt_d = sat_inc(clr_cnt_q);
        end
        2'b11: begin
          state_d   = StUnk;
          inv_cnt_d = sat_inc(inv_cnt_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StUnk;
      exp_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      err_cnt_q  <= '0;
      set_cnt_q  <= '0;
      clr_cnt_q  <= '0;
      inv_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_cnt_q  <= err_cnt_d;
      set_cnt_q  <= set_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
    end
  end

  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_cnt_o  = err_cnt_q;
  assign set_cnt_o  = set_cnt_q;
  assign clr_cnt_o  = clr_cnt_q;
  assign inv_cnt_o  = inv_cnt_q;
  assign mstate_o   = state_q;

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Bench for sr_ff_monitor. Instance A (CNT_W=2, no halt) runs a table of
// vectors; instance B (CNT_W=8, HALT_ON_ERR=1) runs hand-written sequences on
// the same shared inputs after a fresh reset.
module tb_sr_ff_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, s = 1'b0, r = 1'b0, q = 1'b0, qbar = 1'b0, clr = 1'b0;

  logic       a_err, b_err;
  logic [1:0] a_code, b_code, a_st, b_st;
  logic [1:0] a_ecnt, a_set, a_clr, a_inv;
  logic [7:0] b_ecnt, b_set, b_clr, b_inv;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sr_ff_monitor #(.CNT_W(2), .HALT_ON_ERR(1'b0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .s_i(s), .r_i(r), .q_i(q), .qbar_i(qbar),
    .clr_err_i(clr), .err_o(a_err), .err_code_o(a_code), .err_cnt_o(a_ecnt),
    .set_cnt_o(a_set), .clr_cnt_o(a_clr), .inv_cnt_o(a_inv), .mstate_o(a_st)
  );

  sr_ff_monitor #(.CNT_W(8), .HALT_ON_ERR(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .s_i(s), .r_i(r), .q_i(q), .qbar_i(qbar),
    .clr_err_i(clr), .err_o(b_err), .err_code_o(b_code), .err_cnt_o(b_ecnt),
    .set_cnt_o(b_set), .clr_cnt_o(b_clr), .inv_cnt_o(b_inv), .mstate_o(b_st)
  );

  typedef struct {
    logic       rst_n, en, s, r, q, qb, clr;
    logic       e_err;
    logic [1:0] e_code, e_ecnt, e_set, e_clr, e_inv, e_st;
  } vec_t;

  localparam int NVec = 27;
  vec_t vecs [NVec];

  task automatic apply(input logic i_rst_n, input logic i_en, input logic i_s, input logic i_r,
                       input logic i_q, input logic i_qb, input logic i_clr);
    @(negedge clk);
    rst_n = i_rst_n; en = i_en; s = i_s; r = i_r; q = i_q; qbar = i_qb; clr = i_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic w_err, input logic [1:0] w_code,
                       input int w_ecnt, input int w_set, input int w_clr, input int w_inv,
                       input logic [1:0] w_st);
    n_vec++;
    if (b_err !== w_err || b_code !== w_code || b_ecnt !== 8'(w_ecnt) ||
        b_set !== 8'(w_set) || b_clr !== 8'(w_clr) || b_inv !== 8'(w_inv) ||
        b_st !== w_st) begin
      n_fail++;
      $display("FAIL %s: got err=%b code=%b ecnt=%0d set=%0d clr=%0d inv=%0d st=%b, want err=%b code=%b ecnt=%0d set=%0d clr=%0d inv=%0d st=%b",
               name, b_err, b_code, b_ecnt, b_set, b_clr, b_inv, b_st,
               w_err, w_code, w_ecnt, w_set, w_clr, w_inv, w_st);
    end
  endtask

  initial begin
    // rst en s r q qb clr | err code ecnt set clr inv st
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    // Correct flip-flop, commands 00,01,10,11
    vecs[1]  = '{1, 1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    vecs[2]  = '{1, 1, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
    vecs[3]  = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
    vecs[4]  = '{1, 1, 1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    // Complement mismatch in UNK, then clear
    vecs[5]  = '{1, 1, 0, 0, 1, 1, 0, 1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    vecs[6]  = '{1, 1, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    // Set, then q stuck at 0
    vecs[7]  = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1};
    vecs[8]  = '{1, 1, 0, 0, 0, 1, 0, 1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
    // Second cause does not overwrite the first
    vecs[9]  = '{1, 1, 0, 0, 1, 1, 0, 1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    // clr_err with a double mismatch: new cause wins, count restarts at 1
    vecs[10] = '{1, 1, 0, 0, 0, 0, 1, 1, 2'd3, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
    vecs[11] = '{1, 1, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1};
    // err_cnt saturates at 3
    vecs[12] = '{1, 1, 0, 0, 0, 1, 0, 1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
    vecs[13] = '{1, 1, 0, 0, 0, 1, 0, 1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    vecs[14] = '{1, 1, 0, 0, 0, 1, 0, 1, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd1};
    vecs[15] = '{1, 1, 0, 0, 0, 1, 0, 1, 2'd1, 2'd3, 2'd2, 2'd1, 2'd1, 2'd1};
    vecs[16] = '{0, 1, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    // Six consecutive sets, set_cnt holds at 3
    vecs[17] = '{1, 1, 1, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    vecs[18] = '{1, 1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1};
    vecs[19] = '{1, 1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1};
    vecs[20] = '{1, 1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1};
    vecs[21] = '{1, 1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1};
    vecs[22] = '{1, 1, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1};
    // en=0 from TRACK: UNK, no checks, no counting
    vecs[23] = '{1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
    vecs[24] = '{1, 1, 0, 1, 1, 1, 0, 1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd1};
    // clr_err still acts while disabled
    vecs[25] = '{1, 0, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0};
    // Reset overrides en and clr_err
    vecs[26] = '{0, 1, 1, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};

    for (int i = 0; i < NVec; i++) begin
      apply(vecs[i].rst_n, vecs[i].en, vecs[i].s, vecs[i].r, vecs[i].q, vecs[i].qb, vecs[i].clr);
      n_vec++;
      if ({a_err, a_code, a_ecnt, a_set, a_clr, a_inv, a_st} !==
          {vecs[i].e_err, vecs[i].e_code, vecs[i].e_ecnt, vecs[i].e_set, vecs[i].e_clr,
           vecs[i].e_inv, vecs[i].e_st}) begin
        n_fail++;
        $display("FAIL vec%0d: got err=%b code=%b ecnt=%0d set=%0d clr=%0d inv=%0d st=%b, want err=%b code=%b ecnt=%0d set=%0d clr=%0d inv=%0d st=%b",
                 i, a_err, a_code, a_ecnt, a_set, a_clr, a_inv, a_st,
                 vecs[i].e_err, vecs[i].e_code, vecs[i].e_ecnt, vecs[i].e_set,
                 vecs[i].e_clr, vecs[i].e_inv, vecs[i].e_st);
      end
    end

    // Halting instance: build nonzero counters, stuck q halts, HALT is inert
    apply(0, 0, 0, 0, 0, 0, 0); chk_b("b_reset", 0, 2'b00, 0, 0, 0, 0, 2'b00);
    apply(1, 1, 1, 0, 0, 1, 0); chk_b("b_set1",  0, 2'b00, 0, 1, 0, 0, 2'b01);
    apply(1, 1, 0, 1, 1, 0, 0); chk_b("b_clr1",  0, 2'b00, 0, 1, 1, 0, 2'b01);
    apply(1, 1, 1, 1, 0, 1, 0); chk_b("b_inv1",  0, 2'b00, 0, 1, 1, 1, 2'b00);
    apply(1, 1, 1, 0, 0, 1, 0); chk_b("b_set2",  0, 2'b00, 0, 2, 1, 1, 2'b01);
    // Value mismatch halts; the 01 command of this edge is dropped
    apply(1, 1, 0, 1, 0, 1, 0); chk_b("b_halt",  1, 2'b01, 1, 2, 1, 1, 2'b10);
    apply(1, 1, 1, 0, 0, 0, 0); chk_b("b_inert", 1, 2'b01, 1, 2, 1, 1, 2'b10);
    apply(0, 1, 1, 0, 0, 1, 0); chk_b("b_rst_halt", 0, 2'b00, 0, 0, 0, 0, 2'b00);
    // clr_err releases HALT to UNK
    apply(1, 1, 1, 0, 0, 1, 0); chk_b("b_set_a", 0, 2'b00, 0, 1, 0, 0, 2'b01);
    apply(1, 1, 0, 0, 0, 1, 0); chk_b("b_halt2", 1, 2'b01, 1, 1, 0, 0, 2'b10);
    apply(1, 1, 0, 0, 0, 0, 1); chk_b("b_clr_halt", 0, 2'b00, 0, 1, 0, 0, 2'b00);
    apply(1, 1, 1, 0, 0, 1, 0); chk_b("b_resume", 0, 2'b00, 0, 2, 0, 0, 2'b01);
    // Double mismatch halts; 11 command not counted
    apply(1, 1, 1, 1, 0, 0, 0); chk_b("b_halt3", 1, 2'b11, 1, 2, 0, 0, 2'b10);
    // en=0 forces HALT to UNK, error status kept
    apply(1, 0, 0, 0, 0, 1, 0); chk_b("b_en_off", 1, 2'b11, 1, 2, 0, 0, 2'b00);
    apply(1, 1, 1, 0, 1, 0, 0); chk_b("b_after", 1, 2'b11, 1, 3, 0, 0, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_ff_monitor.md
SR_FF_MONITOR -- requirements
Module: sr_ff_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of every event counter.
REQ-002 The block SHALL have parameter HALT_ON_ERR, default 0; when 1, the first mismatch freezes checking.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  monitor enable; 0 suspends checking and counting.
REQ-006 s  input  1  set command driven to the observed SR flip-flop.
REQ-007 r  input  1  reset command driven to the observed SR flip-flop.
REQ-008 q  input  1  observed flip-flop output.
REQ-009 qbar  input  1  observed complementary output.
REQ-010 clr_err  input  1  single-cycle pulse; clears error status.
REQ-011 err  output  1  sticky error flag.
REQ-012 err_code  output  2  first-error cause: 01 value mismatch, 10 complement mismatch, 11 both in the same cycle.
REQ-013 err_cnt  output  CNT_W  count of cycles with any mismatch, saturating.
REQ-014 set_cnt, clr_cnt, inv_cnt  output  CNT_W each  counts of s/r = 10, 01, 11 commands, saturating.
REQ-015 mstate  output  2  FSM state: 00 UNK, 01 TRACK, 10 HALT.

Function
REQ-016 The block SHALL hold an expected-value register exp_q and a 3-state FSM (UNK, TRACK, HALT).
REQ-017 At each rising edge with en=1 and state not HALT, the block SHALL first check the current q/qbar and then update exp_q/state from the current s/r.
REQ-018 Value check: in TRACK, q != exp_q SHALL be a value mismatch; in UNK the value check SHALL be skipped.
REQ-019 Complement check: in UNK or TRACK, qbar == q SHALL be a complement mismatch.
REQ-020 Command decode SHALL be: 10 -> exp_q=1, go TRACK, set_cnt+1; 01 -> exp_q=0, go TRACK, clr_cnt+1; 00 -> hold exp_q and state; 11 -> go UNK, inv_cnt+1.
REQ-021 Latency: a command sampled at edge k SHALL be checked against q sampled at edge k+1; err SHALL be visible after edge k+1.
REQ-022 On any mismatch: err=1, err_cnt+1; err_code SHALL be written only when err was 0, so the first cause is retained.
REQ-023 With HALT_ON_ERR=1, a mismatch SHALL move the FSM to HALT; the command of that same edge SHALL NOT update exp_q or the counters.
REQ-024 In HALT the block SHALL perform no checks, no counting and no exp_q update until rst or clr_err.
REQ-025 clr_err=1 SHALL clear err, err_code and err_cnt, and SHALL move HALT to UNK.
REQ-026 If clr_err coincides with a new mismatch, the new mismatch SHALL win: err=1, err_code = new cause, err_cnt=1.
REQ-027 en=0 SHALL force the FSM to UNK (from TRACK or HALT), and SHALL perform no checks or counter changes; clr_err SHALL still act.
REQ-028 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 rst=0 at a rising edge SHALL set the FSM to UNK, exp_q=0, err=0, err_code=00 and all counters 0, overriding en and clr_err.
REQ-031 Reset asserted mid-operation, including in HALT, SHALL take effect at that edge with no residual state.
REQ-032 On the first edge with rst=1 the block SHALL resume normal operation, starting in UNK.

Verification
REQ-033 After reset, s/r sequence 00,01,10,11 with a correct flip-flop (en=1) -> err=0, clr_cnt=1, set_cnt=1, inv_cnt=1, mstate=00 at end.
REQ-034 Command 10, then q stuck at 0 on the next edge -> err=1, err_code=01, err_cnt=1 one edge later; with HALT_ON_ERR=1, mstate=10.
REQ-035 qbar forced equal to q for one cycle while in UNK -> err=1, err_code=10, value check not applied.
REQ-036 Mismatch and clr_err in the same cycle -> err=1, err_cnt=1; clr_err alone next cycle -> err=0, err_cnt=0, err_code=00.
REQ-037 CNT_W=2, six consecutive 10 commands -> set_cnt=3, held at 3.
REQ-038 rst=0 in HALT with all counters nonzero -> all outputs zero and mstate=00 after that edge; en=0 while in TRACK -> mstate=00 and no checks or counting.
